inv_sub_bytes_seq: RTL and testbench

Area-reduced AES InvSubBytes engine for the decryption datapath of the composite-field AES core. It accepts one 32-bit state column and returns the inverse S-box of each byte. Each byte takes the inverse affine transform followed by GF(2^8) multiplicative inversion. The four bytes are processed serially through a single shared GF_MULINV_8 instance, behind valid/ready handshakes on both sides.

---
 rtl/inv_sub_bytes_seq.sv | 126 ++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes on one 32-bit column, one byte per cycle through a single
// shared inverse-affine + GF(2^8) inverter, with valid/ready on both sides.

module gf_mulinv_8 (
    input  logic [7:0] a,
    output logic [7:0] z
);
    // Multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] m;
        acc = 8'h00;
        m   = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] pw;
    logic [7:0] prod;

    // a^254 = a^-1 for nonzero a, and 0 maps to 0.
    always_comb begin
        pw   = a;
        prod = 8'h01;
        for (int i = 0; i < 7; i++) begin
            pw   = gf_mul(pw, pw);
            prod = gf_mul(prod, pw);
        end
        z = prod;
    end
endmodule

module inv_sub_bytes_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [31:0] y_q, y_d;

    logic [7:0] sel_byte;
    logic [7:0] aff_byte;
    logic [7:0] inv_byte;

    assign sel_byte = word_q[{idx_q, 3'b000} +: 8];
    assign aff_byte = {sel_byte[6:0], sel_byte[7]}
                    ^ {sel_byte[4:0], sel_byte[7:5]}
                    ^ {sel_byte[1:0], sel_byte[7:2]}
                    ^ 8'h05;

    gf_mulinv_8 u_inv (
        .a (aff_byte),
        .z (inv_byte)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = x;
                    idx_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                y_d[{idx_q, 3'b000} +: 8] = inv_byte;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                // Drain and accept on the same edge to avoid a bubble.
                if (out_ready) begin
                    if (in_valid) begin
                        word_d  = x;
                        idx_d   = 2'd0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            word_q  <= 32'h0;
            y_q     <= 32'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            y_q     <= y_d;
        end
    end

    // Gated by rst_n so nothing is accepted while reset is held.
    assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign y         = y_q;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: directed handshake/reset cases plus every byte
// in every lane against a brute-force S-box model.

module tb_inv_sub_bytes_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    always #5 clk = ~clk;

    inv_sub_bytes_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int r, aa;
        r  = 0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa << 1;
            if (aa > 255) aa = aa ^ 'h11b;
        end
        return r[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // Forward S-box from its definition (brute-force inverse, then affine);
    // the inverse table is read off by reversing it.
    task automatic build_model();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[a] = s;
            isbox[s] = a[7:0];
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = isbox[w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] fwd_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox[w[8*i +: 8]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transfer from IDLE with a random downstream stall; returns y.
    task automatic xfer(input logic [31:0] xv, output logic [31:0] yv);
        int t;
        x = xv;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin tick(); t++; end
        if (!in_ready) chk("in_ready_tmo", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        x = $urandom;
        t = 0;
        while (!out_valid && t < 10) begin tick(); t++; end
        if (!out_valid) chk("out_valid_tmo", 32'(out_valid), 32'd1);
        repeat ($urandom_range(0, 3)) tick();
        yv = y;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [31:0] y0, yv;
    logic [7:0]  perm [256];
    logic [7:0]  tmp;
    int          j, p1, p2, seen;
    logic [31:0] w, got1, got2;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = 32'h0;
        build_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_y", y, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single word: latency and busy window
        x = 32'h637C777B;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_in_ready_drop", 32'(in_ready), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            chk("single_busy", 32'(busy), 32'd1);
            chk("single_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("single_busy4", 32'(busy), 32'd1);
        tick();
        chk("single_busy_end", 32'(busy), 32'd0);
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_y", y, ref_word(32'h637C777B));
        chk("single_y_const", y, 32'h00010203);

        // Backpressure in DONE with a competing in_valid
        y0 = y;
        x = 32'h16ED6300;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_y", y, y0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("drain_accept_busy", 32'(busy), 32'd1);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        repeat (4) tick();
        chk("boundary_valid", 32'(out_valid), 32'd1);
        chk("boundary_y", y, 32'hFF530052);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_after_drain", 32'(in_ready), 32'd1);

        // Back-to-back with out_ready held high
        x = 32'h637C777B;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        x = 32'h16ED6300;
        p1 = -1; p2 = -1; seen = 0;
        got1 = 32'h0; got2 = 32'h0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (out_valid) begin
                if (seen == 0) begin p1 = i; got1 = y; end
                else if (seen == 1) begin p2 = i; got2 = y; in_valid = 1'b0; end
                seen++;
            end
        end
        out_ready = 1'b0;
        chk("b2b_count", 32'(seen), 32'd2);
        chk("b2b_first_at", 32'(p1), 32'd4);
        chk("b2b_gap", 32'(p2 - p1), 32'd5);
        chk("b2b_y0", got1, 32'h00010203);
        chk("b2b_y1", got2, 32'hFF530052);

        // Reset during the second BUSY cycle
        x = 32'h16ED6300;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_y", y, 32'h0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);
        xfer(32'h637C777B, yv);
        chk("post_rst_word", yv, 32'h00010203);

        // Every byte value in every lane, random order
        for (int i = 0; i < 256; i++) perm[i] = i[7:0];
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 64; k++) begin
                for (int i = 0; i < 4; i++) w[8*i +: 8] = perm[4*k + ((i + r) % 4)];
                xfer(w, yv);
                chk("exh_y", yv, ref_word(w));
                chk("exh_roundtrip", fwd_word(yv), w);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule
